// File: rtl/input_feeder.sv
`timescale 1ns/1ps
// Read-side feeder for one input memory bank: streams num_rows rows from base_addr to the array.
// Optional INPUT_FEEDER_ZERO_PAD_EN appends ARRAY_SIZE-1 zero beats to flush the array.
module input_feeder #(
  parameter int ARRAY_SIZE = 128,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [ADDR_WIDTH:0]              num_rows,
  output logic                             busy,
  output logic                             done,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] mem_dout,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data,
  output logic                             out_last
);

  localparam int ROW_W = ARRAY_SIZE * DATA_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int NUM_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
`ifdef INPUT_FEEDER_ZERO_PAD_EN
    S_PAD   = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [NUM_W-1:0]      num_reg;
  logic [NUM_W-1:0]      issued_reg;
  logic                  inflight_reg;
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [ROW_W-1:0]      fifo_mem [FIFO_DEPTH];

  logic             accept_start;
  logic             can_issue;
  logic             last_issue;
  logic             push;
  logic             fifo_valid;
  logic             fifo_pop;
  logic             drain_ok;
  logic [CNT_W-1:0] occupancy;
  logic [ROW_W-1:0] head_row;

  assign accept_start = (state_reg == S_IDLE) && start;

  // out_ready is deliberately absent here: issue depends only on registered occupancy.
  assign occupancy  = count_reg + CNT_W'(inflight_reg);
  assign can_issue  = occupancy < DEPTH_C;
  assign mem_en     = (state_reg == S_RUN) && can_issue;
  assign mem_we     = 1'b0;
  assign mem_addr   = mem_en ? (base_reg + issued_reg[ADDR_WIDTH-1:0]) : '0;
  assign last_issue = mem_en && (issued_reg == (num_reg - NUM_W'(1)));

  assign push       = inflight_reg;
  assign fifo_valid = (count_reg != '0);
  assign fifo_pop   = fifo_valid && out_ready;
  assign head_row   = fifo_mem[rd_ptr_reg];

  // Finishing on the cycle the final row is popped lets done follow the last beat directly.
  assign drain_ok = !inflight_reg &&
                    ((count_reg == '0) || ((count_reg == CNT_W'(1)) && fifo_pop));

  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        fifo_valid ? head_row[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

`ifdef INPUT_FEEDER_ZERO_PAD_EN
  localparam int PAD_BEATS = ARRAY_SIZE - 1;
  localparam int PAD_W     = $clog2(ARRAY_SIZE) + 1;

  logic [PAD_W-1:0] pad_cnt_reg;
  logic             pad_last;

  assign pad_last  = (state_reg == S_PAD) && (pad_cnt_reg == PAD_W'(PAD_BEATS - 1));
  assign out_valid = fifo_valid || (state_reg == S_PAD);
  assign out_last  = pad_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_cnt_reg <= '0;
    end else if (state_reg != S_PAD) begin
      pad_cnt_reg <= '0;
    end else if (out_ready) begin
      pad_cnt_reg <= pad_cnt_reg + PAD_W'(1);
    end
  end
`else
  logic [NUM_W-1:0] popped_reg;

  assign out_valid = fifo_valid;
  assign out_last  = fifo_valid && (popped_reg == (num_reg - NUM_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      popped_reg <= '0;
    end else if (accept_start) begin
      popped_reg <= '0;
    end else if (fifo_pop) begin
      popped_reg <= popped_reg + NUM_W'(1);
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (num_rows == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_issue) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_ok) begin
`ifdef INPUT_FEEDER_ZERO_PAD_EN
          state_next = (PAD_BEATS > 0) ? S_PAD : S_DONE;
`else
          state_next = S_DONE;
`endif
        end
      end
`ifdef INPUT_FEEDER_ZERO_PAD_EN
      S_PAD: begin
        if (pad_last && out_ready) begin
          state_next = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign done = (state_reg == S_DONE);
`ifdef INPUT_FEEDER_ZERO_PAD_EN
  assign busy = (state_reg == S_RUN) || (state_reg == S_DRAIN) || (state_reg == S_PAD);
`else
  assign busy = (state_reg == S_RUN) || (state_reg == S_DRAIN);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      base_reg     <= '0;
      num_reg      <= '0;
      issued_reg   <= '0;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= mem_en;
      if (accept_start) begin
        base_reg   <= base_addr;
        num_reg    <= num_rows;
        issued_reg <= '0;
      end else if (mem_en) begin
        issued_reg <= issued_reg + NUM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      unique case ({push, fifo_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Row storage carries no reset; out_data is gated by fifo_valid instead.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= mem_dout;
    end
  end

endmodule

// File: tb/tb_input_feeder.sv
`timescale 1ns/1ps
// Randomised bench for input_feeder: a memory model plus an expected-beat queue built from the job rules.
module tb_input_feeder;

`ifdef INPUT_FEEDER_ZERO_PAD_EN
  localparam int AS  = 4;
  localparam bit PAD = 1'b1;
`else
  localparam int AS  = 128;
  localparam bit PAD = 1'b0;
`endif
  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int FD    = 4;
  localparam int W     = AS * DW;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_rows;
  logic          busy;
  logic          done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_dout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;

  input_feeder #(
    .ARRAY_SIZE(AS),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .num_rows(num_rows),
    .busy(busy),
    .done(done),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_dout(mem_dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last)
  );

  logic [W-1:0]  mem [DEPTH];
  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  bit           job_active = 0;
  int           start_edge = 0;
  int           job_num = 0;
  bit           ready_rand = 0;
  bit           first_issue_seen = 0;
  bit           first_valid_seen = 0;
  bit           done_seen = 0;
  bit           have_prev_beat = 0;
  int           prev_beat_cyc = 0;
  int           beats = 0;
  int           issues = 0;
  int           pops = 0;
  bit           prev_stall = 0;
  bit           prev_done = 0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 0;
  beat_t        mon_b;
  logic [AW-1:0] mon_a;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (low 64 bits)", tag, got[63:0], exp[63:0]);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read memory: data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) mem_dout <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      prev_done  = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", out_last, prev_last);
      end
      if (prev_done) chk("done_pulse", done, 0);
      if (job_active && !done_seen && (cyc + 1 > start_edge)) chk("busy", busy, !done);
      if (mem_en) begin
        chk("mem_we", mem_we, 0);
        chk("issue_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) begin
          mon_a = addr_q.pop_front();
          chk("mem_addr", mem_addr, mon_a);
        end
        if (!first_issue_seen) begin
          chk("issue_lat", cyc + 1 - start_edge, 1);
          first_issue_seen = 1;
        end
        chk("occupancy", (issues - pops) < FD, 1);
        issues++;
      end
      if (out_valid && !first_valid_seen) begin
        chk("valid_lat", cyc + 1 - start_edge, 3);
        first_valid_seen = 1;
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_b = exp_q.pop_front();
          chk("out_data", out_data, mon_b.data);
          chk("out_last", out_last, mon_b.last);
        end
        if (!ready_rand && have_prev_beat) chk("throughput", cyc + 1 - prev_beat_cyc, 1);
        prev_beat_cyc  = cyc + 1;
        have_prev_beat = 1;
        beats++;
        pops++;
      end
      if (done) begin
        chk("done_expected", job_active && !done_seen, 1);
        chk("rows_left", exp_q.size(), 0);
        if (job_num == 0) chk("done_lat", cyc + 1 - start_edge, 1);
        else              chk("done_after_last", cyc + 1 - prev_beat_cyc, 1);
        done_seen = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_done  = done;
    end
  end

  task automatic fill_index();
    for (int r = 0; r < DEPTH; r++)
      for (int l = 0; l < AS; l++) mem[r][l*DW +: DW] = DW'(r);
  endtask

  task automatic fill_random();
    for (int r = 0; r < DEPTH; r++)
      for (int l = 0; l < AS; l++) mem[r][l*DW +: DW] = DW'($urandom);
  endtask

  task automatic start_job(input int base, input int num, input bit rrand);
    beat_t bb;
    exp_q.delete();
    addr_q.delete();
    for (int i = 0; i < num; i++) begin
      addr_q.push_back(AW'((base + i) % DEPTH));
      bb.data = mem[(base + i) % DEPTH];
      bb.last = !PAD && (i == num - 1);
      exp_q.push_back(bb);
    end
    if (PAD && num > 0) begin
      for (int j = 0; j < AS - 1; j++) begin
        bb.data = '0;
        bb.last = (j == AS - 2);
        exp_q.push_back(bb);
      end
    end
    job_num = num; ready_rand = rrand;
    first_issue_seen = 0; first_valid_seen = 0; done_seen = 0; have_prev_beat = 0;
    issues = 0; pops = 0; beats = 0;
    @(posedge clk); #1;
    base_addr  = AW'(base);
    num_rows   = (AW+1)'(num);
    start      = 1'b1;
    start_edge = cyc + 1;
    job_active = 1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    num_rows  = (AW+1)'($urandom);
  endtask

  task automatic wait_done(input int budget, input bit inject);
    int i = 0;
    while (!done_seen && i < budget) begin
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && i == 4) begin
        start = 1'b1; base_addr = 6'd33; num_rows = 7'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      i++;
    end
    start = 1'b0;
    if (!done_seen) chk("timeout", 0, 1);
    job_active = 0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int quiet;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; out_ready = 1'b1; mem_dout = '0;
    fill_index();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;

    start_job(0, 8, 0);   wait_done(100, 0);
    fill_random();
    start_job(62, 4, 0);  wait_done(100, 0);
    start_job(0, 16, 1);  wait_done(400, 1);
    start_job(0, 0, 0);   wait_done(20, 0);

    start_job(20, 10, 0);
    k = 0;
    while (beats < 3 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    chk("rst_wait_beats", beats, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_mem_en", mem_en, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_last", out_last, 0);
    chk("abort_out_data", out_data, 0);
    job_active = 0;
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    quiet = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || mem_en || busy || done) quiet++;
    end
    chk("abort_quiet", quiet, 0);

    start_job(5, 2, 0);   wait_done(50, 0);

    for (int j = 0; j < 6; j++) begin
      start_job($urandom_range(0, DEPTH - 1), $urandom_range(1, DEPTH), 1'($urandom_range(0, 1)));
      wait_done(2000, 0);
    end
    start_job($urandom_range(0, DEPTH - 1), DEPTH, 0);
    wait_done(500, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/input_feeder.md
Name: input_feeder

Overview:
- Read-side controller for one dual-port input memory bank (A or B operand); owns one memory port, read-only.
- On `start`, reads `num_rows` consecutive rows from `base_addr` and streams them as full-width vectors to the systolic array over a valid/ready interface.
- Absorbs the memory's 1-cycle registered read latency and output backpressure with an internal FIFO, so no row is lost or duplicated.

Parameters:
- ARRAY_SIZE, 128, lanes per row vector.
- DATA_WIDTH, 16, bits per lane.
- ADDR_WIDTH, 6, memory address width (depth 2^ADDR_WIDTH = 64).
- FIFO_DEPTH, 4, output buffer entries; power of 2, >=2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle job request; accepted only in IDLE.
- base_addr  in  ADDR_WIDTH  first row address, sampled on an accepted start.
- num_rows  in  ADDR_WIDTH+1  rows to read (0..2^ADDR_WIDTH), sampled on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the job completes.
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory write enable; constant 0.
- mem_addr  out  ADDR_WIDTH  memory port address.
- mem_dout  in  ARRAY_SIZE*DATA_WIDTH  memory read data, valid the cycle after mem_en.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when valid&&ready.
- out_data  out  ARRAY_SIZE*DATA_WIDTH  row vector, lane 0 in LSBs.
- out_last  out  1  marks the final beat of the job.

Behaviour:
- Reset values: busy=0, done=0, mem_en=0, mem_addr=0, out_valid=0, out_last=0, out_data=0. FIFO is emptied, in-flight read is discarded, state is IDLE.
- FSM states: IDLE, RUN, DRAIN, PAD (PAD exists only with the optional feature), DONE.
- IDLE: on start, latch base_addr/num_rows and clear the issue counter. Go to RUN if num_rows>0, else DONE.
- RUN issue rule, evaluated each cycle:
  - Set mem_en=1 and mem_addr=base+issued (mod 2^ADDR_WIDTH) when fifo_count + inflight < FIFO_DEPTH.
  - inflight = mem_en registered from the previous cycle.
  - out_ready is not used in the issue decision, so there is no combinational ready->mem_en path.
- Capture: in the cycle after mem_en, mem_dout is written into the FIFO at the clock edge.
- RUN -> DRAIN: in the cycle the last row is issued.
- DRAIN: waits until the FIFO is empty with no read in flight and the final beat has been accepted.
- Address wrap-around: base=62, num_rows=4 reads 62, 63, 0, 1.
- Latency: start at edge T0 puts the first mem_en in cycle T0+1, with out_valid=1 from cycle T0+3.
- Throughput: one row per cycle with out_ready held high.
- Handshake:
  - out_data and out_last are stable while out_valid && !out_ready.
  - out_valid stays high until the beat is accepted.
  - A FIFO push and pop in the same cycle leave the count unchanged.
- out_last=1 on the final job beat: the last row, or the last pad beat when padding is enabled.
- DONE: done=1 for exactly one cycle, busy drops in the same cycle, then return to IDLE. busy=1 in RUN, DRAIN and PAD.
- start while not in IDLE is ignored, with no effect on the running job.
- Asserting rst mid-job aborts immediately; no further out_valid beats until a new start.

Optional Feature:
- Macro: INPUT_FEEDER_ZERO_PAD_EN.
- Defined:
  - After DRAIN, enter PAD and emit ARRAY_SIZE-1 all-zero beats under the same handshake, to flush the systolic array.
  - out_last is on the final pad beat, and DONE follows.
  - num_rows=0 still goes straight to DONE with no pad.
- Undefined:
  - No PAD state; DRAIN goes to DONE.
  - out_last is on the last row beat.

Test Plan:
- Basic read: memory rows 0..7 preloaded with row index in every lane; start base=0, num_rows=8, out_ready=1.
  - Expect 8 beats with values 0..7 on consecutive cycles, first out_valid at T0+3.
  - Expect out_last on beat 7, then done one cycle later as a single pulse.
- Wrap-around: start base=62, num_rows=4.
  - Expect mem_addr sequence 62, 63, 0, 1 and output data in that order.
- Backpressure: base=0, num_rows=16, out_ready toggling 1,0,0,1,… pseudo-randomly.
  - Expect all 16 rows exactly once, in order, with out_data stable while stalled.
  - Expect fifo_count+inflight never to exceed 4.
- Zero length: num_rows=0.
  - Expect no mem_en, no out_valid, done pulse at T0+1.
  - A start asserted during a running job is ignored.
- Reset mid-job: assert rst after 3 beats of a num_rows=10 job.
  - Expect all outputs at 0 immediately and no further beats.
  - A new job (base=5, num_rows=2) then returns rows 5, 6.
- Padding (INPUT_FEEDER_ZERO_PAD_EN defined, ARRAY_SIZE=4): num_rows=2.
  - Expect 2 data beats, then 3 zero beats with out_last on the 5th, then done.
